// File: rtl/clock5_pkg.sv
// ---------------------------------------------------------------------------
// clock5_pkg
//   Shared definitions for the CLOCK5 timer subsystem: duration width,
//   reset value of phase durations, the system tick rate and the state
//   encoding of the phase sequencer.
// ---------------------------------------------------------------------------
package clock5_pkg;

  // Width of a duration in seconds; matches the timer's secondsToCount.
  localparam int SEC_W = 16;

  // Power-up duration of every phase table entry.
  localparam int DEFAULT_SEC = 5;

  // System clock rate: one CLK period is one 100 us tick.
  localparam int CLK_HZ = 10_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_WAIT_ACK,
    ST_RUN,
    ST_NEXT,
    ST_ERROR
  } seq_state_e;

endpackage

// File: rtl/timer_phase_sequencer_phase_table.sv
// ---------------------------------------------------------------------------
// phase_table
//   NUM_PHASES x SEC_W register file holding the duration of each phase.
//   Single write port, combinational read port.
// Ports
//   CLK    in   1      system clock, rising edge
//   reset  in   1      asynchronous, active-high; loads DEFAULT_SEC everywhere
//   we     in   1      write strobe
//   waddr  in   PH_W   entry to write
//   wdata  in   SEC_W  value to write
//   raddr  in   PH_W   entry to read
//   rdata  out  SEC_W  contents of entry raddr (combinational)
// ---------------------------------------------------------------------------
module phase_table
  import clock5_pkg::*;
#(
  parameter  int NUM_PHASES  = 4,
  parameter  int SEC_W       = clock5_pkg::SEC_W,
  parameter  int DEFAULT_SEC = clock5_pkg::DEFAULT_SEC,
  localparam int PH_W        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             we,
  input  logic [PH_W-1:0]  waddr,
  input  logic [SEC_W-1:0] wdata,
  input  logic [PH_W-1:0]  raddr,
  output logic [SEC_W-1:0] rdata
);

  logic [SEC_W-1:0] entries [NUM_PHASES];

  // NOTE: the table must come out of reset holding DEFAULT_SEC, so it is
  // built from resettable flops instead of being left to infer a RAM.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        entries[i] <= SEC_W'(DEFAULT_SEC);
      end
    end else if (we) begin
      entries[waddr] <= wdata;
    end
  end

  assign rdata = entries[raddr];

endmodule

// File: rtl/timer_phase_sequencer.sv
// ---------------------------------------------------------------------------
// timer_phase_sequencer
//   Initiator side of the seconds-timer interface. Steps through a
//   programmable table of phase durations: for each phase it presents the
//   duration on secondsToCount, pulses timer_start, waits for the timer to
//   acknowledge (finished falls) and then to expire (finished rises).
//   Zero-length phases are skipped without involving the timer.
// Ports
//   CLK             in   1      10 kHz system clock, rising edge
//   reset           in   1      asynchronous, active-high
//   go              in   1      start a sequence at phase 0 (IDLE only)
//   abort           in   1      return to IDLE from any state, clears error
//   loop_en         in   1      restart at phase 0 after the last phase
//   cfg_we          in   1      table write strobe (IDLE only)
//   cfg_addr        in   PH_W   table entry to write
//   cfg_data        in   SEC_W  duration in seconds
//   finished        in   1      timer status: 1 idle/expired, 0 counting
//   secondsToCount  out  SEC_W  duration presented to the timer
//   timer_start     out  1      one-cycle start request
//   phase           out  PH_W   current phase index
//   busy            out  1      sequence in progress (not IDLE, not ERROR)
//   phase_done      out  1      one-cycle pulse per completed/skipped phase
//   seq_done        out  1      one-cycle pulse at end of a non-looping run
//   error           out  1      sticky: timer never acknowledged a start
// ---------------------------------------------------------------------------
module timer_phase_sequencer
  import clock5_pkg::*;
#(
  parameter  int SEC_W       = clock5_pkg::SEC_W,
  parameter  int NUM_PHASES  = 4,
  parameter  int ACK_TIMEOUT = 8,
  parameter  int DEFAULT_SEC = clock5_pkg::DEFAULT_SEC,
  localparam int PH_W        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             go,
  input  logic             abort,
  input  logic             loop_en,
  input  logic             cfg_we,
  input  logic [PH_W-1:0]  cfg_addr,
  input  logic [SEC_W-1:0] cfg_data,
  input  logic             finished,
  output logic [SEC_W-1:0] secondsToCount,
  output logic             timer_start,
  output logic [PH_W-1:0]  phase,
  output logic             busy,
  output logic             phase_done,
  output logic             seq_done,
  output logic             error
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  seq_state_e       state;
  seq_state_e       next_state;
  logic [ACK_W-1:0] ack_cnt;
  logic [SEC_W-1:0] entry;
  logic             table_we;
  logic             last_phase;
  logic             ack_last;

  // Next-cycle values of the registered outputs.
  logic busy_d;
  logic timer_start_d;
  logic phase_done_d;
  logic seq_done_d;
  logic error_d;

  // abort outranks cfg_we, so a write is dropped in the cycle abort is seen.
  assign table_we   = (state == ST_IDLE) && cfg_we && !abort;
  assign last_phase = (phase == PH_W'(NUM_PHASES - 1));
  // The counter reaches ACK_TIMEOUT on the same edge that enters ERROR,
  // i.e. ERROR follows exactly ACK_TIMEOUT cycles spent in WAIT_ACK.
  assign ack_last   = (ack_cnt == ACK_W'(ACK_TIMEOUT - 1));

  phase_table #(
    .NUM_PHASES  (NUM_PHASES),
    .SEC_W       (SEC_W),
    .DEFAULT_SEC (DEFAULT_SEC)
  ) u_phase_table (
    .CLK   (CLK),
    .reset (reset),
    .we    (table_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (phase),
    .rdata (entry)
  );

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: next_state takes a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:     if (go) next_state = ST_LOAD;
        ST_LOAD:     next_state = (entry == '0) ? ST_NEXT : ST_ARM;
        ST_ARM:      next_state = ST_WAIT_ACK;
        ST_WAIT_ACK: begin
          if (!finished)     next_state = ST_RUN;
          else if (ack_last) next_state = ST_ERROR;
        end
        ST_RUN:      if (finished) next_state = ST_NEXT;
        ST_NEXT:     next_state = (last_phase && !loop_en) ? ST_IDLE : ST_LOAD;
        ST_ERROR:    next_state = ST_ERROR;
        default:     next_state = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output logic: decoded from the state being entered, then registered so
  // each output is a clean flop that lines up with its state.
  // -------------------------------------------------------------------------
  always_comb begin
    busy_d        = (next_state != ST_IDLE) && (next_state != ST_ERROR);
    timer_start_d = (next_state == ST_ARM);
    phase_done_d  = (next_state == ST_NEXT);
    // NEXT -> IDLE without abort is only the natural end of a run.
    seq_done_d    = (state == ST_NEXT) && (next_state == ST_IDLE) && !abort;
    error_d       = (next_state == ST_ERROR);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      timer_start <= 1'b0;
      phase_done  <= 1'b0;
      seq_done    <= 1'b0;
      error       <= 1'b0;
    end else begin
      busy        <= busy_d;
      timer_start <= timer_start_d;
      phase_done  <= phase_done_d;
      seq_done    <= seq_done_d;
      error       <= error_d;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: phase index, presented duration, acknowledge counter
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      phase          <= '0;
      secondsToCount <= '0;
      ack_cnt        <= '0;
    end else begin
      // Every entry into LOAD picks the phase to run: advance from a
      // non-last NEXT, otherwise (go from IDLE, or loop wrap) start at 0.
      // A finished non-looping run leaves phase at the last index.
      if (next_state == ST_LOAD) begin
        phase <= (state == ST_NEXT && !last_phase) ? phase + PH_W'(1) : '0;
      end

      // Loaded on leaving LOAD, so the duration is already valid during
      // ARM when the timer sees the start request.
      if (state == ST_LOAD && !abort) begin
        secondsToCount <= entry;
      end

      if (state == ST_ARM) begin
        ack_cnt <= '0;
      end else if (state == ST_WAIT_ACK && finished &&
                   ack_cnt != ACK_W'(ACK_TIMEOUT)) begin
        ack_cnt <= ack_cnt + ACK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_timer_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_timer_phase_sequencer
//   Self-checking bench for timer_phase_sequencer. A behavioural timer
//   model answers timer_start; a scoreboard queue holds the expected
//   start / phase_done / seq_done events, pushed when a run is launched and
//   popped by a monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_timer_phase_sequencer;
  import clock5_pkg::*;

  localparam int NP          = 4;
  localparam int ACK_TIMEOUT = 8;
  localparam int TICKS       = 2;  // model cycles per "second"

  typedef logic [NP-1:0][15:0] tbl4_t;

  typedef struct {
    tbl4_t tbl;
    int    exp_starts;
  } vec_t;

  typedef enum int {EV_START, EV_PDONE, EV_SDONE} ev_kind_e;

  typedef struct {
    ev_kind_e    kind;
    logic [1:0]  ph;
    logic [15:0] sec;
  } ev_t;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        loop_en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        finished;
  logic [15:0] secondsToCount;
  logic        timer_start;
  logic [1:0]  phase;
  logic        busy;
  logic        phase_done;
  logic        seq_done;
  logic        error;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_starts = 0;
  ev_t  sb_q [$];
  logic t_stuck = 1'b0;
  logic t_pend;
  int   t_left;

  timer_phase_sequencer #(
    .SEC_W       (16),
    .NUM_PHASES  (NP),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .DEFAULT_SEC (5)
  ) dut (
    .CLK            (CLK),
    .reset          (reset),
    .go             (go),
    .abort          (abort),
    .loop_en        (loop_en),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .finished       (finished),
    .secondsToCount (secondsToCount),
    .timer_start    (timer_start),
    .phase          (phase),
    .busy           (busy),
    .phase_done     (phase_done),
    .seq_done       (seq_done),
    .error          (error)
  );

  always #5 CLK = ~CLK;

  // Timer model: acknowledges a start one cycle later by dropping finished,
  // then counts secondsToCount*TICKS cycles and raises finished again.
  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      finished <= 1'b1;
      t_pend   <= 1'b0;
      t_left   <= 0;
    end else if (timer_start && !t_stuck) begin
      t_pend <= 1'b1;
      t_left <= int'(secondsToCount) * TICKS;
    end else if (t_pend) begin
      t_pend   <= 1'b0;
      finished <= 1'b0;
    end else if (!finished) begin
      if (t_left <= 1) finished <= 1'b1;
      else             t_left   <= t_left - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic sb_push(input ev_kind_e k, input logic [1:0] p, input logic [15:0] s);
    ev_t e;
    e.kind = k;
    e.ph   = p;
    e.sec  = s;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input ev_kind_e k);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_unexpected: got event %s at phase %0d, expected none (t=%0t)",
               k.name(), phase, $time);
    end else begin
      e = sb_q.pop_front();
      check("sb_kind", k, e.kind);
      check("sb_phase", phase, e.ph);
      if (k == EV_START) check("sb_sec", secondsToCount, e.sec);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the
  // active edge.
  always @(negedge CLK) begin
    if (!reset) begin
      if (timer_start) begin
        n_starts++;
        sb_pop(EV_START);
      end
      if (phase_done) sb_pop(EV_PDONE);
      if (seq_done)   sb_pop(EV_SDONE);
    end
  end

  // Expected event stream of one non-looping run over table t.
  task automatic push_seq(input tbl4_t t);
    for (int p = 0; p < NP; p++) begin
      if (t[p] != 16'd0) sb_push(EV_START, 2'(p), t[p]);
      sb_push(EV_PDONE, 2'(p), 16'd0);
    end
    sb_push(EV_SDONE, 2'(NP - 1), 16'd0);
  endtask

  function automatic tbl4_t mk(input int e0, input int e1, input int e2, input int e3);
    tbl4_t t;
    t[0] = 16'(e0);
    t[1] = 16'(e1);
    t[2] = 16'(e2);
    t[3] = 16'(e3);
    return t;
  endfunction

  // All driving tasks start and end just after a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick(1);
    cfg_we   = 1'b0;
  endtask

  task automatic load_table(input tbl4_t t);
    for (int p = 0; p < NP; p++) cfg_write(2'(p), t[p]);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic wait_start(input string name, input logic [1:0] ph, input int budget);
    int n = 0;
    while (!(timer_start && phase == ph) && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_start_timeout"}, timer_start, 1'b1);
  endtask

  initial begin
    vec_t vecs [5];
    int   busy_low;
    int   n;

    vecs[0] = '{tbl: mk(3, 0, 2, 1), exp_starts: 3};
    vecs[1] = '{tbl: mk(0, 0, 0, 0), exp_starts: 0};
    vecs[2] = '{tbl: mk(1, 2, 1, 2), exp_starts: 4};
    vecs[3] = '{tbl: mk(0, 0, 0, 4), exp_starts: 1};
    vecs[4] = '{tbl: mk(2, 0, 0, 0), exp_starts: 1};

    // ---- reset state ----
    reset = 1'b1;
    tick(2);
    check("rst_busy", busy, 1'b0);
    check("rst_sec", secondsToCount, 16'd0);
    check("rst_start", timer_start, 1'b0);
    check("rst_phase", phase, 2'd0);
    check("rst_error", error, 1'b0);
    check("rst_pdone", phase_done, 1'b0);
    check("rst_sdone", seq_done, 1'b0);
    reset = 1'b0;
    tick(2);

    // ---- table-driven one-shot runs ----
    for (int v = 0; v < 5; v++) begin
      load_table(vecs[v].tbl);
      push_seq(vecs[v].tbl);
      n_starts = 0;
      pulse_go();
      check("vec_busy", busy, 1'b1);
      wait_idle("vec", 500);
      tick(2);
      check("vec_final_phase", phase, 2'd3);
      check("vec_starts", n_starts, vecs[v].exp_starts);
      check("vec_sb_empty", sb_q.size(), 0);
      check("vec_error", error, 1'b0);
    end

    // ---- loop_en wraps to phase 0, busy never drops ----
    load_table(mk(1, 1, 1, 1));
    for (int p = 0; p < NP; p++) begin
      sb_push(EV_START, 2'(p), 16'd1);
      sb_push(EV_PDONE, 2'(p), 16'd0);
    end
    sb_push(EV_START, 2'd0, 16'd1);
    loop_en  = 1'b1;
    n_starts = 0;
    busy_low = 0;
    n        = 0;
    pulse_go();
    while (n_starts < 5 && n < 1000) begin
      tick(1);
      n++;
      if (!busy) busy_low++;
    end
    check("loop_starts", n_starts, 5);
    check("loop_busy_low", busy_low, 0);
    check("loop_phase", phase, 2'd0);
    abort = 1'b1;
    tick(1);
    abort   = 1'b0;
    loop_en = 1'b0;
    check("loop_abort_busy", busy, 1'b0);
    tick(4);
    check("loop_sb_empty", sb_q.size(), 0);

    // ---- acknowledge timeout -> ERROR ----
    do_reset();
    t_stuck = 1'b1;
    sb_push(EV_START, 2'd0, 16'd5);
    pulse_go();
    wait_start("ack", 2'd0, 20);
    tick(ACK_TIMEOUT);
    check("ack_error_early", error, 1'b0);
    check("ack_busy_early", busy, 1'b1);
    tick(1);
    check("ack_error", error, 1'b1);
    check("ack_busy", busy, 1'b0);
    pulse_go();
    check("ack_go_ignored", error, 1'b1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("ack_abort_error", error, 1'b0);
    check("ack_abort_busy", busy, 1'b0);
    t_stuck = 1'b0;
    tick(2);
    check("ack_sb_empty", sb_q.size(), 0);

    // ---- abort in RUN at phase 2, then restart ----
    do_reset();
    load_table(mk(1, 1, 3, 1));
    sb_push(EV_START, 2'd0, 16'd1);
    sb_push(EV_PDONE, 2'd0, 16'd0);
    sb_push(EV_START, 2'd1, 16'd1);
    sb_push(EV_PDONE, 2'd1, 16'd0);
    sb_push(EV_START, 2'd2, 16'd3);
    pulse_go();
    wait_start("abort", 2'd2, 200);
    tick(4);
    check("abort_pre_busy", busy, 1'b1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_pdone", phase_done, 1'b0);
    check("abort_sdone", seq_done, 1'b0);
    tick(12);
    check("abort_sb_empty", sb_q.size(), 0);
    push_seq(mk(1, 1, 3, 1));
    pulse_go();
    wait_idle("restart", 500);
    tick(2);
    check("restart_sb_empty", sb_q.size(), 0);

    // ---- cfg_we ignored outside IDLE; write+go in the same cycle ----
    do_reset();
    load_table(mk(2, 0, 1, 1));
    push_seq(mk(2, 0, 1, 1));
    pulse_go();
    wait_start("cfg", 2'd0, 20);
    tick(3);
    cfg_write(2'd1, 16'd9);
    wait_idle("cfg_run", 500);
    tick(2);
    check("cfg_busy_write_dropped", sb_q.size(), 0);
    cfg_write(2'd1, 16'd9);
    push_seq(mk(4, 9, 1, 1));
    n_starts = 0;
    cfg_we   = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = 16'd4;
    go       = 1'b1;
    tick(1);
    cfg_we = 1'b0;
    go     = 1'b0;
    wait_idle("cfg_idle", 500);
    tick(2);
    check("cfg_idle_sb_empty", sb_q.size(), 0);
    check("cfg_idle_starts", n_starts, 4);

    // ---- async reset mid-WAIT_ACK restores defaults ----
    load_table(mk(1, 1, 1, 1));
    sb_push(EV_START, 2'd0, 16'd1);
    pulse_go();
    wait_start("areset", 2'd0, 20);
    @(posedge CLK);
    #2;
    reset = 1'b1;
    #1;
    check("areset_busy", busy, 1'b0);
    check("areset_sec", secondsToCount, 16'd0);
    check("areset_start", timer_start, 1'b0);
    check("areset_phase", phase, 2'd0);
    check("areset_error", error, 1'b0);
    tick(1);
    reset = 1'b0;
    tick(1);
    check("areset_sb_empty", sb_q.size(), 0);
    push_seq(mk(5, 5, 5, 5));
    pulse_go();
    wait_idle("default", 1000);
    tick(2);
    check("default_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
